// File: rtl/loop_activity_monitor_pkg.sv
// Shared types and helpers for the loop activity monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`timescale 1ns/1ps
package loop_mon_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int SAT_MAX_W = 64;
    localparam int SEQ_MAX_W = 64;

    // The seq-loop encodings are zero-extended into a fixed-width carrier.
    // Zero-extension keeps equality compares exact for any STATE_W up to 64.
    typedef struct packed {
        logic [SEQ_MAX_W-1:0] pre0;
        logic [SEQ_MAX_W-1:0] pre1;
        logic [SEQ_MAX_W-1:0] iter_start;
        logic [SEQ_MAX_W-1:0] iter_end;
        logic [SEQ_MAX_W-1:0] quit;
        logic [SEQ_MAX_W-1:0] post;
    } seq_states_t;

    // Saturating increment of a counter that is w bits wide (1..64),
    // carried zero-extended in a 64-bit value.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                    input int unsigned w);
        logic [SAT_MAX_W-1:0] mx;
        mx = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
        return (v >= mx) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/loop_activity_monitor_if.sv
// Probe bundle from the instrumented HLS design into the activity monitor.
// Latency: n/a (wires only).
// Backpressure: none; master drives probes, slave (monitor) only observes.
`timescale 1ns/1ps
interface loop_activity_monitor_if #(
    parameter int STATE_W     = 23,
    parameter int UPC_STATE_W = 1
);
    logic                   mod_ap_start;
    logic                   mod_ap_ready;
    logic                   mod_ap_done;
    logic                   mod_ap_continue;
    logic [STATE_W-1:0]     seq_cur_state;
    logic [STATE_W-1:0]     seq_pre_state0;
    logic [STATE_W-1:0]     seq_pre_state1;
    logic [1:0]             seq_pre_valid;
    logic [STATE_W-1:0]     seq_iter_start_state;
    logic [STATE_W-1:0]     seq_iter_end_state;
    logic [STATE_W-1:0]     seq_quit_state;
    logic [STATE_W-1:0]     seq_post_state;
    logic                   seq_one_state_loop;
    logic                   seq_one_state_block;
    logic [UPC_STATE_W-1:0] upc_cur_state;
    logic [UPC_STATE_W-1:0] upc_iter_start_state;
    logic [UPC_STATE_W-1:0] upc_iter_end_state;
    logic                   upc_iter_start_enable;
    logic                   upc_iter_end_enable;
    logic                   upc_iter_start_block;
    logic                   upc_iter_end_block;
    logic                   upc_loop_start;
    logic                   upc_loop_ready;
    logic                   upc_loop_done;
    logic                   upc_loop_continue;

    modport master (
        output mod_ap_start, mod_ap_ready, mod_ap_done, mod_ap_continue,
        output seq_cur_state, seq_pre_state0, seq_pre_state1, seq_pre_valid,
        output seq_iter_start_state, seq_iter_end_state, seq_quit_state, seq_post_state,
        output seq_one_state_loop, seq_one_state_block,
        output upc_cur_state, upc_iter_start_state, upc_iter_end_state,
        output upc_iter_start_enable, upc_iter_end_enable,
        output upc_iter_start_block, upc_iter_end_block,
        output upc_loop_start, upc_loop_ready, upc_loop_done, upc_loop_continue
    );

    modport slave (
        input mod_ap_start, mod_ap_ready, mod_ap_done, mod_ap_continue,
        input seq_cur_state, seq_pre_state0, seq_pre_state1, seq_pre_valid,
        input seq_iter_start_state, seq_iter_end_state, seq_quit_state, seq_post_state,
        input seq_one_state_loop, seq_one_state_block,
        input upc_cur_state, upc_iter_start_state, upc_iter_end_state,
        input upc_iter_start_enable, upc_iter_end_enable,
        input upc_iter_start_block, upc_iter_end_block,
        input upc_loop_start, upc_loop_ready, upc_loop_done, upc_loop_continue
    );
endinterface

// File: rtl/handshake_lat_counter.sv
// Tracks an ap_start/ap_done transaction: busy flag, completed count, last latency.
// Latency: outputs registered, update one clock after the sampled start/done.
// Backpressure: none; hold freezes all state. Ports: start, done (already
// qualified with continue), hold in; busy, txn_cnt, last_lat out.
`timescale 1ns/1ps
module handshake_lat_counter
    import loop_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             start,
    input  logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] last_lat
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
    endfunction

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] lat_q, lat_d;

    always_comb begin
        busy_d = busy_q;
        acc_d  = acc_q;
        txn_d  = txn_q;
        lat_d  = lat_q;
        if (!hold) begin
            if (start && !busy_q) begin
                busy_d = 1'b1;
                acc_d  = ONE;
            end else if (busy_q) begin
                acc_d = inc(acc_q);
            end
            // The done cycle itself counts toward latency when already busy;
            // a done seen while idle is a one-cycle transaction.
            if (done) begin
                txn_d  = inc(txn_q);
                lat_d  = busy_q ? inc(acc_q) : ONE;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            acc_q  <= '0;
            txn_q  <= '0;
            lat_q  <= '0;
        end else begin
            busy_q <= busy_d;
            acc_q  <= acc_d;
            txn_q  <= txn_d;
            lat_q  <= lat_d;
        end
    end

    assign busy     = busy_q;
    assign txn_cnt  = txn_q;
    assign last_lat = lat_q;
endmodule

// File: rtl/loop_activity_monitor.sv
// Profiles an HLS design: module handshake, FSM-sequenced loop, pipelined loop.
// Latency: all outputs registered, one clock after the sampled event.
// Backpressure: none; pure observer, finish freezes every register until reset.
// Ports: clock/reset/finish, probe (slave modport); mod_*, seq_*, upc_* counters, mon_done.
`timescale 1ns/1ps
module loop_activity_monitor
    import loop_mon_pkg::*;
#(
    parameter int STATE_W     = 23,
    parameter int UPC_STATE_W = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             finish,
    loop_activity_monitor_if.slave probe,
    output logic             mod_busy,
    output logic [CNT_W-1:0] mod_txn_cnt,
    output logic [CNT_W-1:0] mod_last_lat,
    output logic             seq_active,
    output logic [CNT_W-1:0] seq_iter_cnt,
    output logic [CNT_W-1:0] seq_loop_cnt,
    output logic [CNT_W-1:0] seq_last_trip,
    output logic             upc_active,
    output logic [CNT_W-1:0] upc_istart_cnt,
    output logic [CNT_W-1:0] upc_iend_cnt,
    output logic [CNT_W-1:0] upc_loop_cnt,
    output logic             mon_done
);
    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
    endfunction

    logic               mon_done_q, mon_done_d;
    logic [STATE_W-1:0] prev_state_q, prev_state_d;
    logic               seq_active_q, seq_active_d;
    logic [CNT_W-1:0]   seq_iter_q, seq_iter_d;
    logic [CNT_W-1:0]   seq_loop_q, seq_loop_d;
    logic [CNT_W-1:0]   seq_trip_q, seq_trip_d;
    logic               upc_active_q, upc_active_d;
    logic [CNT_W-1:0]   upc_istart_q, upc_istart_d;
    logic [CNT_W-1:0]   upc_iend_q, upc_iend_d;
    logic [CNT_W-1:0]   upc_loop_q, upc_loop_d;

    // ap_ready handshakes are not needed for profiling.
    logic unused_probes;
    assign unused_probes = probe.mod_ap_ready ^ probe.upc_loop_ready;

    handshake_lat_counter #(.CNT_W(CNT_W)) u_mod_lat (
        .clock    (clock),
        .reset    (reset),
        .hold     (mon_done_q),
        .start    (probe.mod_ap_start),
        .done     (probe.mod_ap_done & probe.mod_ap_continue),
        .busy     (mod_busy),
        .txn_cnt  (mod_txn_cnt),
        .last_lat (mod_last_lat)
    );

    seq_states_t        enc;
    logic [SEQ_MAX_W-1:0] cur_x, prev_x;
    logic               seq_entry_evt, seq_iter_evt, seq_exit_evt;

    always_comb begin
        enc.pre0       = SEQ_MAX_W'(probe.seq_pre_state0);
        enc.pre1       = SEQ_MAX_W'(probe.seq_pre_state1);
        enc.iter_start = SEQ_MAX_W'(probe.seq_iter_start_state);
        enc.iter_end   = SEQ_MAX_W'(probe.seq_iter_end_state);
        enc.quit       = SEQ_MAX_W'(probe.seq_quit_state);
        enc.post       = SEQ_MAX_W'(probe.seq_post_state);
        cur_x          = SEQ_MAX_W'(probe.seq_cur_state);
        prev_x         = SEQ_MAX_W'(prev_state_q);
    end

    assign seq_entry_evt = (cur_x == enc.iter_start) &&
                           ((probe.seq_pre_valid[0] && (prev_x == enc.pre0)) ||
                            (probe.seq_pre_valid[1] && (prev_x == enc.pre1)));
    // A single-state loop never visits a distinct end state, so each
    // unstalled cycle in the start state is one iteration.
    assign seq_iter_evt  = probe.seq_one_state_loop ?
                           ((cur_x == enc.iter_start) && !probe.seq_one_state_block) :
                           (cur_x == enc.iter_end);
    assign seq_exit_evt  = seq_active_q && (prev_x == enc.quit) && (cur_x == enc.post);

    logic [UPC_STATE_W-1:0] upc_cur, upc_start_st, upc_end_st;
    logic                   upc_istart_evt, upc_iend_evt, upc_done_evt;

    assign upc_cur        = probe.upc_cur_state;
    assign upc_start_st   = probe.upc_iter_start_state;
    assign upc_end_st     = probe.upc_iter_end_state;
    assign upc_istart_evt = (upc_cur == upc_start_st) && probe.upc_iter_start_enable &&
                            !probe.upc_iter_start_block;
    assign upc_iend_evt   = (upc_cur == upc_end_st) && probe.upc_iter_end_enable &&
                            !probe.upc_iter_end_block;
    assign upc_done_evt   = probe.upc_loop_done && probe.upc_loop_continue;

    always_comb begin
        mon_done_d   = mon_done_q;
        prev_state_d = prev_state_q;
        seq_active_d = seq_active_q;
        seq_iter_d   = seq_iter_q;
        seq_loop_d   = seq_loop_q;
        seq_trip_d   = seq_trip_q;
        upc_active_d = upc_active_q;
        upc_istart_d = upc_istart_q;
        upc_iend_d   = upc_iend_q;
        upc_loop_d   = upc_loop_q;
        if (!mon_done_q) begin
            mon_done_d   = finish;
            prev_state_d = probe.seq_cur_state;

            // Order matters: iteration, then exit (captures the trip count
            // including this cycle's iteration), then a possible re-entry.
            if (seq_active_q && seq_iter_evt) seq_iter_d = inc(seq_iter_q);
            if (seq_exit_evt) begin
                seq_active_d = 1'b0;
                seq_loop_d   = inc(seq_loop_q);
                seq_trip_d   = seq_iter_d;
            end
            if (!seq_active_d && seq_entry_evt) begin
                seq_active_d = 1'b1;
                seq_iter_d   = '0;
            end

            if (upc_istart_evt) upc_istart_d = inc(upc_istart_q);
            if (upc_iend_evt)   upc_iend_d   = inc(upc_iend_q);
            if (probe.upc_loop_start && !upc_active_q) upc_active_d = 1'b1;
            if (upc_done_evt) begin
                upc_loop_d   = inc(upc_loop_q);
                upc_active_d = probe.upc_loop_start;  // back-to-back keeps it open
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mon_done_q   <= 1'b0;
            prev_state_q <= '0;
            seq_active_q <= 1'b0;
            seq_iter_q   <= '0;
            seq_loop_q   <= '0;
            seq_trip_q   <= '0;
            upc_active_q <= 1'b0;
            upc_istart_q <= '0;
            upc_iend_q   <= '0;
            upc_loop_q   <= '0;
        end else begin
            mon_done_q   <= mon_done_d;
            prev_state_q <= prev_state_d;
            seq_active_q <= seq_active_d;
            seq_iter_q   <= seq_iter_d;
            seq_loop_q   <= seq_loop_d;
            seq_trip_q   <= seq_trip_d;
            upc_active_q <= upc_active_d;
            upc_istart_q <= upc_istart_d;
            upc_iend_q   <= upc_iend_d;
            upc_loop_q   <= upc_loop_d;
        end
    end

    assign mon_done       = mon_done_q;
    assign seq_active     = seq_active_q;
    assign seq_iter_cnt   = seq_iter_q;
    assign seq_loop_cnt   = seq_loop_q;
    assign seq_last_trip  = seq_trip_q;
    assign upc_active     = upc_active_q;
    assign upc_istart_cnt = upc_istart_q;
    assign upc_iend_cnt   = upc_iend_q;
    assign upc_loop_cnt   = upc_loop_q;
endmodule

// File: tb/tb_loop_activity_monitor.sv
// Directed bench for loop_activity_monitor: a 32-bit and a 4-bit instance
// observe the same probe bundle; the 4-bit one exercises saturation.
`timescale 1ns/1ps
module tb_loop_activity_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic finish = 1'b0;
    logic finish4 = 1'b0;

    always #5 clock = ~clock;

    loop_activity_monitor_if #(.STATE_W(23), .UPC_STATE_W(1)) pif ();

    logic        mod_busy, seq_active, upc_active, mon_done;
    logic [31:0] mod_txn_cnt, mod_last_lat, seq_iter_cnt, seq_loop_cnt, seq_last_trip;
    logic [31:0] upc_istart_cnt, upc_iend_cnt, upc_loop_cnt;

    logic        s_mod_busy, s_seq_active, s_upc_active, s_mon_done;
    logic [3:0]  s_mod_txn_cnt, s_mod_last_lat, s_seq_iter_cnt, s_seq_loop_cnt, s_seq_last_trip;
    logic [3:0]  s_upc_istart_cnt, s_upc_iend_cnt, s_upc_loop_cnt;

    loop_activity_monitor #(.STATE_W(23), .UPC_STATE_W(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .finish(finish), .probe(pif),
        .mod_busy(mod_busy), .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
        .seq_active(seq_active), .seq_iter_cnt(seq_iter_cnt), .seq_loop_cnt(seq_loop_cnt),
        .seq_last_trip(seq_last_trip), .upc_active(upc_active),
        .upc_istart_cnt(upc_istart_cnt), .upc_iend_cnt(upc_iend_cnt),
        .upc_loop_cnt(upc_loop_cnt), .mon_done(mon_done)
    );

    loop_activity_monitor #(.STATE_W(23), .UPC_STATE_W(1), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .finish(finish4), .probe(pif),
        .mod_busy(s_mod_busy), .mod_txn_cnt(s_mod_txn_cnt), .mod_last_lat(s_mod_last_lat),
        .seq_active(s_seq_active), .seq_iter_cnt(s_seq_iter_cnt), .seq_loop_cnt(s_seq_loop_cnt),
        .seq_last_trip(s_seq_last_trip), .upc_active(s_upc_active),
        .upc_istart_cnt(s_upc_istart_cnt), .upc_iend_cnt(s_upc_iend_cnt),
        .upc_loop_cnt(s_upc_loop_cnt), .mon_done(s_mon_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs are changed and outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [22:0] st(input int n);
        logic [22:0] one;
        one = 23'd1;
        return one << (n - 1);
    endfunction

    // Start sampled in one cycle, done sampled 'gap' cycles later: latency gap+1.
    task automatic mod_txn(input int gap);
        pif.mod_ap_start = 1'b1;
        step();
        pif.mod_ap_start = 1'b0;
        repeat (gap - 1) step();
        pif.mod_ap_done = 1'b1;
        pif.mod_ap_continue = 1'b1;
        step();
        pif.mod_ap_done = 1'b0;
        pif.mod_ap_continue = 1'b0;
    endtask

    initial begin
        pif.mod_ap_start = 1'b0;          pif.mod_ap_ready = 1'b0;
        pif.mod_ap_done = 1'b0;           pif.mod_ap_continue = 1'b0;
        pif.seq_cur_state = st(1);
        pif.seq_pre_state0 = st(4);       pif.seq_pre_state1 = st(9);
        pif.seq_pre_valid = 2'b01;
        pif.seq_iter_start_state = st(17); pif.seq_iter_end_state = st(23);
        pif.seq_quit_state = st(17);      pif.seq_post_state = st(1);
        pif.seq_one_state_loop = 1'b0;    pif.seq_one_state_block = 1'b0;
        pif.upc_cur_state = 1'b1;         pif.upc_iter_start_state = 1'b1;
        pif.upc_iter_end_state = 1'b1;
        pif.upc_iter_start_enable = 1'b0; pif.upc_iter_end_enable = 1'b0;
        pif.upc_iter_start_block = 1'b0;  pif.upc_iter_end_block = 1'b0;
        pif.upc_loop_start = 1'b0;        pif.upc_loop_ready = 1'b0;
        pif.upc_loop_done = 1'b0;         pif.upc_loop_continue = 1'b0;

        // Reset state
        step(); step();
        check("rst_mod_busy", mod_busy, 0);
        check("rst_mod_txn", mod_txn_cnt, 0);
        check("rst_mod_lat", mod_last_lat, 0);
        check("rst_seq_active", seq_active, 0);
        check("rst_seq_iter", seq_iter_cnt, 0);
        check("rst_seq_loop", seq_loop_cnt, 0);
        check("rst_seq_trip", seq_last_trip, 0);
        check("rst_upc_active", upc_active, 0);
        check("rst_upc_istart", upc_istart_cnt, 0);
        check("rst_upc_iend", upc_iend_cnt, 0);
        check("rst_upc_loop", upc_loop_cnt, 0);
        check("rst_mon_done", mon_done, 0);
        reset = 1'b0;
        step();

        // Module handshake: done 4 cycles after start
        mod_txn(4);
        check("txn1_cnt", mod_txn_cnt, 1);
        check("txn1_lat", mod_last_lat, 5);
        check("txn1_busy", mod_busy, 0);
        mod_txn(4);
        mod_txn(4);
        check("txn3_cnt", mod_txn_cnt, 3);

        // Reset in the middle of a fourth transaction
        pif.mod_ap_start = 1'b1;
        step();
        pif.mod_ap_start = 1'b0;
        check("txn4_busy", mod_busy, 1);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_busy", mod_busy, 0);
        check("midrst_txn", mod_txn_cnt, 0);
        check("midrst_lat", mod_last_lat, 0);
        check("midrst_mon_done", mon_done, 0);
        reset = 1'b0;
        step();

        repeat (4) mod_txn(4);
        check("rep4_cnt", mod_txn_cnt, 4);
        check("rep4_lat", mod_last_lat, 5);

        // Same-cycle start and done while idle
        pif.mod_ap_start = 1'b1;
        pif.mod_ap_done = 1'b1;
        pif.mod_ap_continue = 1'b1;
        step();
        pif.mod_ap_start = 1'b0;
        pif.mod_ap_done = 1'b0;
        pif.mod_ap_continue = 1'b0;
        check("same_cnt", mod_txn_cnt, 5);
        check("same_lat", mod_last_lat, 1);
        check("same_busy", mod_busy, 0);

        mod_txn(2);
        check("short_lat", mod_last_lat, 3);
        check("short_cnt", mod_txn_cnt, 6);

        // Done without continue is not a completion
        pif.mod_ap_done = 1'b1;
        step();
        check("nocont_cnt", mod_txn_cnt, 6);
        // Done without a preceding start
        pif.mod_ap_continue = 1'b1;
        step();
        pif.mod_ap_done = 1'b0;
        pif.mod_ap_continue = 1'b0;
        check("orphan_cnt", mod_txn_cnt, 7);
        check("orphan_lat", mod_last_lat, 1);

        // Seq loop: enter from state4, 7 iterations via state23, exit 17 -> 1
        pif.seq_cur_state = st(4);  step();
        pif.seq_cur_state = st(17); step();
        check("seq_entry_active", seq_active, 1);
        check("seq_entry_iter", seq_iter_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            pif.seq_cur_state = st(23); step();
            pif.seq_cur_state = st(17); step();
        end
        check("seq_iter7", seq_iter_cnt, 7);
        pif.seq_cur_state = st(1); step();
        check("seq_exit_loop", seq_loop_cnt, 1);
        check("seq_exit_trip", seq_last_trip, 7);
        check("seq_exit_active", seq_active, 0);

        // Predecessor state9 is not qualified: no entry
        pif.seq_cur_state = st(9);  step();
        pif.seq_cur_state = st(17); step();
        check("seq_badpre_active", seq_active, 0);
        pif.seq_cur_state = st(1);  step();

        // One-state loop: 10 cycles in state17, two of them stalled
        pif.seq_one_state_loop = 1'b1;
        pif.seq_cur_state = st(4);  step();
        pif.seq_cur_state = st(17); step();
        check("one_entry_iter", seq_iter_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            pif.seq_one_state_block = (i == 3) || (i == 7);
            step();
        end
        pif.seq_one_state_block = 1'b0;
        check("one_iter8", seq_iter_cnt, 8);
        pif.seq_cur_state = st(1); step();
        check("one_loop_cnt", seq_loop_cnt, 2);
        check("one_trip", seq_last_trip, 8);
        pif.seq_one_state_loop = 1'b0;

        // Pipelined loop: 16 enabled cycles, 2 stalls, then completion
        pif.upc_loop_start = 1'b1; step();
        pif.upc_loop_start = 1'b0;
        check("upc_start_active", upc_active, 1);
        pif.upc_iter_start_enable = 1'b1;
        pif.upc_iter_end_enable = 1'b1;
        repeat (16) step();
        pif.upc_iter_start_block = 1'b1;
        pif.upc_iter_end_block = 1'b1;
        repeat (2) step();
        pif.upc_iter_start_enable = 1'b0;
        pif.upc_iter_end_enable = 1'b0;
        pif.upc_iter_start_block = 1'b0;
        pif.upc_iter_end_block = 1'b0;
        check("upc_istart16", upc_istart_cnt, 16);
        check("upc_iend16", upc_iend_cnt, 16);
        pif.upc_loop_done = 1'b1;
        pif.upc_loop_continue = 1'b1;
        step();
        pif.upc_loop_done = 1'b0;
        pif.upc_loop_continue = 1'b0;
        check("upc_loop1", upc_loop_cnt, 1);
        check("upc_done_active", upc_active, 0);

        // Back-to-back invocation keeps the loop active
        pif.upc_loop_start = 1'b1; step();
        pif.upc_loop_done = 1'b1;
        pif.upc_loop_continue = 1'b1;
        step();
        check("upc_b2b_loop", upc_loop_cnt, 2);
        check("upc_b2b_active", upc_active, 1);
        pif.upc_loop_start = 1'b0;
        step();
        pif.upc_loop_done = 1'b0;
        pif.upc_loop_continue = 1'b0;
        check("upc_b2b_end_loop", upc_loop_cnt, 3);
        check("upc_b2b_end_active", upc_active, 0);

        // Freeze: the finish cycle still counts, later activity does not
        finish = 1'b1;
        pif.mod_ap_done = 1'b1;
        pif.mod_ap_continue = 1'b1;
        step();
        finish = 1'b0;
        check("frz_mon_done", mon_done, 1);
        check("frz_edge_cnt", mod_txn_cnt, 8);
        repeat (10) step();
        pif.mod_ap_done = 1'b0;
        pif.mod_ap_continue = 1'b0;
        pif.upc_loop_start = 1'b1;
        step();
        pif.upc_loop_start = 1'b0;
        check("frz_txn_held", mod_txn_cnt, 8);
        check("frz_lat_held", mod_last_lat, 1);
        check("frz_upc_active_held", upc_active, 0);
        check("frz_seq_loop_held", seq_loop_cnt, 2);
        check("frz_mon_done_sticky", mon_done, 1);

        // 4-bit instance: 18 completions and 16 iteration starts saturate
        check("sat_txn", s_mod_txn_cnt, 15);
        check("sat_istart", s_upc_istart_cnt, 15);
        check("sat_trip", s_seq_last_trip, 8);
        check("sat_mon_done", s_mon_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
